// File: rtl/game_referee_if.sv
// Bus between the game referee and its environment: match control in,
// counter-drive and match-status signals out.
interface game_referee_if;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned MODE_W = 2;

  logic              start;
  logic              load_en;
  logic [CNT_W-1:0]  load_val;
  logic [MODE_W-1:0] mode_sel;
  logic              winner;
  logic              loser;
  logic [MODE_W-1:0] control;
  logic              init;
  logic [CNT_W-1:0]  initial_val;
  logic              counter_rst;
  logic [CNT_W-1:0]  win_count;
  logic [CNT_W-1:0]  lose_count;
  logic              gameover;
  logic [1:0]        who;
  logic              protocol_err;

  modport master (
    output start, load_en, load_val, mode_sel, winner, loser,
    input  control, init, initial_val, counter_rst,
           win_count, lose_count, gameover, who, protocol_err
  );

  modport slave (
    input  start, load_en, load_val, mode_sel, winner, loser,
    output control, init, initial_val, counter_rst,
           win_count, lose_count, gameover, who, protocol_err
  );
endinterface

// File: rtl/game_referee.sv
// Match referee for the multimode counter: sequences the counter reset/seed,
// tallies round results and declares the match over at WIN_LIMIT.
module game_referee #(
  parameter int unsigned WIN_LIMIT = 15
) (
  input  logic           clk,
  input  logic           rst,
  game_referee_if.slave  bus
);
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned MODE_W = 2;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, OVER} state_e;

  state_e state_q, state_d;

  logic [MODE_W-1:0] control_q, control_d;
  logic              init_q, init_d;
  logic [CNT_W-1:0]  initial_val_q, initial_val_d;
  logic              counter_rst_q, counter_rst_d;
  logic [CNT_W-1:0]  win_count_q, win_count_d;
  logic [CNT_W-1:0]  lose_count_q, lose_count_d;
  logic              gameover_q, gameover_d;
  logic [1:0]        who_q, who_d;
  logic              protocol_err_q, protocol_err_d;

  logic win_only, lose_only, both_pulse, win_hit, lose_hit;

  assign win_only   = bus.winner & ~bus.loser;
  assign lose_only  = bus.loser & ~bus.winner;
  assign both_pulse = bus.winner & bus.loser;
  // Limit is only reachable from RUN, so counts never pass WIN_LIMIT
  assign win_hit  = win_only  && ((win_count_q  + CNT_W'(1)) == CNT_W'(WIN_LIMIT));
  assign lose_hit = lose_only && ((lose_count_q + CNT_W'(1)) == CNT_W'(WIN_LIMIT));

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = bus.load_en ? LOAD : RUN;
      LOAD:    state_d = RUN;
      RUN:     if (win_hit || lose_hit) state_d = OVER;
      OVER:    if (bus.start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values for the registered outputs; strobes follow the state being entered
  always_comb begin
    control_d      = control_q;
    initial_val_d  = initial_val_q;
    win_count_d    = win_count_q;
    lose_count_d   = lose_count_q;
    who_d          = who_q;
    protocol_err_d = protocol_err_q;
    init_d         = (state_d == LOAD);
    counter_rst_d  = (state_d != RUN);
    gameover_d     = (state_d == OVER);
    case (state_q)
      IDLE: if (bus.start) initial_val_d = bus.load_val;
      RUN: begin
        control_d = bus.mode_sel;
        if (both_pulse) protocol_err_d = 1'b1;
        if (win_only)   win_count_d  = win_count_q + CNT_W'(1);
        if (lose_only)  lose_count_d = lose_count_q + CNT_W'(1);
        if (win_hit)    who_d = 2'b10;
        if (lose_hit)   who_d = 2'b01;
      end
      OVER: if (bus.start) begin
        win_count_d  = '0;
        lose_count_d = '0;
        who_d        = 2'b00;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      control_q      <= '0;
      init_q         <= 1'b0;
      initial_val_q  <= '0;
      counter_rst_q  <= 1'b1;
      win_count_q    <= '0;
      lose_count_q   <= '0;
      gameover_q     <= 1'b0;
      who_q          <= 2'b00;
      protocol_err_q <= 1'b0;
    end else begin
      control_q      <= control_d;
      init_q         <= init_d;
      initial_val_q  <= initial_val_d;
      counter_rst_q  <= counter_rst_d;
      win_count_q    <= win_count_d;
      lose_count_q   <= lose_count_d;
      gameover_q     <= gameover_d;
      who_q          <= who_d;
      protocol_err_q <= protocol_err_d;
    end
  end

  assign bus.control      = control_q;
  assign bus.init         = init_q;
  assign bus.initial_val  = initial_val_q;
  assign bus.counter_rst  = counter_rst_q;
  assign bus.win_count    = win_count_q;
  assign bus.lose_count   = lose_count_q;
  assign bus.gameover     = gameover_q;
  assign bus.who          = who_q;
  assign bus.protocol_err = protocol_err_q;
endmodule

// File: tb/tb_game_referee.sv
// Bench for game_referee: two instances (limits 3 and 15) share one stimulus
// stream and are compared every cycle against a match-level reference model.
module tb_game_referee;
  logic       clk = 1'b0;
  logic       rst;
  logic       start, load_en, winner, loser;
  logic [3:0] load_val;
  logic [1:0] mode_sel;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] P_IDLE = 2'd0, P_LOAD = 2'd1, P_RUN = 2'd2, P_OVER = 2'd3;

  typedef struct packed {
    logic [1:0] phase;
    logic [1:0] ctrl;
    logic       init;
    logic [3:0] ival;
    logic       crst;
    logic [3:0] wc;
    logic [3:0] lc;
    logic       go;
    logic [1:0] who;
    logic       perr;
  } mdl_t;

  mdl_t m3, m15;

  game_referee_if b3 ();
  game_referee_if b15 ();

  assign b3.start = start;   assign b15.start = start;
  assign b3.load_en = load_en; assign b15.load_en = load_en;
  assign b3.load_val = load_val; assign b15.load_val = load_val;
  assign b3.mode_sel = mode_sel; assign b15.mode_sel = mode_sel;
  assign b3.winner = winner; assign b15.winner = winner;
  assign b3.loser = loser;   assign b15.loser = loser;

  game_referee #(.WIN_LIMIT(3))  dut3  (.clk(clk), .rst(rst), .bus(b3));
  game_referee #(.WIN_LIMIT(15)) dut15 (.clk(clk), .rst(rst), .bus(b15));

  always #5 clk = ~clk;

  function automatic mdl_t reset_mdl();
    mdl_t r;
    r = '0;
    r.phase = P_IDLE;
    r.crst  = 1'b1;
    return r;
  endfunction

  // Match-level behaviour for one clock edge, using the inputs present at that edge
  function automatic mdl_t step(mdl_t m, int lim);
    mdl_t n;
    int   w, l;
    if (rst) return reset_mdl();
    n = m;
    w = int'(m.wc);
    l = int'(m.lc);
    if (m.phase == P_IDLE && start) begin
      n.ival  = load_val;
      n.phase = load_en ? P_LOAD : P_RUN;
    end else if (m.phase == P_LOAD) begin
      n.phase = P_RUN;
    end else if (m.phase == P_RUN) begin
      n.ctrl = mode_sel;
      if (winner && loser) n.perr = 1'b1;
      else if (winner) w = w + 1;
      else if (loser)  l = l + 1;
      if (w > lim) w = lim;
      if (l > lim) l = lim;
      n.wc = 4'(w);
      n.lc = 4'(l);
      if (w == lim && int'(m.wc) != lim) begin n.phase = P_OVER; n.who = 2'b10; end
      if (l == lim && int'(m.lc) != lim) begin n.phase = P_OVER; n.who = 2'b01; end
    end else if (m.phase == P_OVER && start) begin
      n.wc = 4'd0; n.lc = 4'd0; n.who = 2'b00;
      n.phase = P_IDLE;
    end
    n.init = (n.phase == P_LOAD);
    n.crst = (n.phase != P_RUN);
    n.go   = (n.phase == P_OVER);
    return n;
  endfunction

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("d3.control", 4'(b3.control), 4'(m3.ctrl));
    chk("d3.init", 4'(b3.init), 4'(m3.init));
    chk("d3.initial_val", b3.initial_val, m3.ival);
    chk("d3.counter_rst", 4'(b3.counter_rst), 4'(m3.crst));
    chk("d3.win_count", b3.win_count, m3.wc);
    chk("d3.lose_count", b3.lose_count, m3.lc);
    chk("d3.gameover", 4'(b3.gameover), 4'(m3.go));
    chk("d3.who", 4'(b3.who), 4'(m3.who));
    chk("d3.protocol_err", 4'(b3.protocol_err), 4'(m3.perr));
    chk("d15.control", 4'(b15.control), 4'(m15.ctrl));
    chk("d15.init", 4'(b15.init), 4'(m15.init));
    chk("d15.initial_val", b15.initial_val, m15.ival);
    chk("d15.counter_rst", 4'(b15.counter_rst), 4'(m15.crst));
    chk("d15.win_count", b15.win_count, m15.wc);
    chk("d15.lose_count", b15.lose_count, m15.lc);
    chk("d15.gameover", 4'(b15.gameover), 4'(m15.go));
    chk("d15.who", 4'(b15.who), 4'(m15.who));
    chk("d15.protocol_err", 4'(b15.protocol_err), 4'(m15.perr));
  endtask

  task automatic cyc();
    @(posedge clk);
    m3  = step(m3, 3);
    m15 = step(m15, 15);
    #1;
    check_all();
  endtask

  task automatic idle_in();
    start = 1'b0; load_en = 1'b0; load_val = 4'd0;
    winner = 1'b0; loser = 1'b0;
  endtask

  initial begin
    m3 = reset_mdl();
    m15 = reset_mdl();
    idle_in();
    mode_sel = 2'd0;

    // Reset state
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    chk("rst_counter_rst", 4'(b3.counter_rst), 4'd1);
    chk("rst_win_count", b15.win_count, 4'd0);

    // Seeded start
    start = 1'b1; load_en = 1'b1; load_val = 4'd9;
    cyc();
    chk("seed_init", 4'(b3.init), 4'd1);
    chk("seed_ival", b3.initial_val, 4'd9);
    idle_in();
    cyc();
    chk("seed_init_drop", 4'(b3.init), 4'd0);
    chk("seed_run_crst", 4'(b3.counter_rst), 4'd0);

    // Mode change, then wins with one loss interleaved
    mode_sel = 2'd2;
    cyc();
    chk("mode_control", 4'(b3.control), 4'd2);
    winner = 1'b1; cyc();
    winner = 1'b0; loser = 1'b1; cyc();
    loser = 1'b0; winner = 1'b1; cyc();
    cyc();
    winner = 1'b0;
    chk("win3_wc", b3.win_count, 4'd3);
    chk("win3_lc", b3.lose_count, 4'd1);
    chk("win3_who", 4'(b3.who), 4'b0010);
    chk("win3_go", 4'(b3.gameover), 4'd1);
    chk("win3_crst", 4'(b3.counter_rst), 4'd1);
    cyc();

    // Loss limit: fresh match, 15 back-to-back losses plus extras in OVER
    rst = 1'b1; cyc(); rst = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    loser = 1'b1;
    repeat (15) cyc();
    chk("loss15_lc", b15.lose_count, 4'd15);
    chk("loss15_who", 4'(b15.who), 4'b0001);
    repeat (3) cyc();
    winner = 1'b1; loser = 1'b0; cyc(); cyc();
    winner = 1'b0;
    chk("loss15_hold", b15.lose_count, 4'd15);

    // Simultaneous pulses: sticky error survives OVER and start
    rst = 1'b1; cyc(); rst = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    winner = 1'b1; loser = 1'b1; cyc();
    winner = 1'b0; loser = 1'b0;
    chk("both_perr", 4'(b3.protocol_err), 4'd1);
    chk("both_wc", b3.win_count, 4'd0);
    loser = 1'b1; repeat (3) cyc(); loser = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    chk("perr_after_start", 4'(b3.protocol_err), 4'd1);
    chk("over_clear_lc", b3.lose_count, 4'd0);
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("perr_cleared", 4'(b3.protocol_err), 4'd0);

    // Reset during LOAD, and during RUN with two wins
    start = 1'b1; load_en = 1'b1; load_val = 4'd5; cyc();
    idle_in(); rst = 1'b1; cyc(); rst = 1'b0;
    chk("rst_load_init", 4'(b3.init), 4'd0);
    start = 1'b1; cyc(); start = 1'b0;
    winner = 1'b1; cyc(); cyc();
    rst = 1'b1; cyc(); rst = 1'b0; winner = 1'b0;
    chk("rst_run_wc", b15.win_count, 4'd0);
    cyc();

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      rst      = ($urandom_range(0, 99) == 0);
      start    = ($urandom_range(0, 7) == 0);
      load_en  = 1'($urandom_range(0, 1));
      load_val = 4'($urandom_range(0, 15));
      mode_sel = 2'($urandom_range(0, 3));
      winner   = ($urandom_range(0, 2) == 0);
      loser    = ($urandom_range(0, 2) == 0);
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
